// File: rtl/uart_tx_ctrl_if.sv
// Host/shift-register side bundle for the UART transmit sequencer.
interface uart_tx_ctrl_if #(
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
);
    localparam int PKT = DATA_BITS + 1 + STOP_BITS;

    logic                 send;
    logic [DATA_BITS-1:0] data_in;
    logic                 ld;
    logic [1:0]           shift;
    logic [PKT-1:0]       packet;
    logic                 ser_bit;
    logic                 tx;
    logic                 busy;
    logic                 done;

    // Upstream side: host request plus the shift register's serial output
    modport master (
        output send, data_in, ser_bit,
        input  ld, shift, packet, tx, busy, done
    );

    // Sequencer side
    modport slave (
        input  send, data_in, ser_bit,
        output ld, shift, packet, tx, busy, done
    );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: frames a byte, drives load/shift commands to an
// external shift register at baud rate and gates its LSB onto the tx line.
module uart_tx_ctrl #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    uart_tx_ctrl_if.slave bus
);
    localparam int PKT = DATA_BITS + 1 + STOP_BITS;
    localparam int CW  = $clog2(CLKS_PER_BIT);
    localparam int BW  = $clog2(PKT);

    typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;

    state_t         state, state_nxt;
    logic [CW-1:0]  baud_cnt;
    logic [BW-1:0]  bit_cnt;
    logic [PKT-1:0] packet_q;

    logic baud_tc;
    logic last_bit;

    assign baud_tc  = (baud_cnt == CW'(CLKS_PER_BIT - 1));
    assign last_bit = (bit_cnt == BW'(PKT - 1));

    // State register, frame capture and baud/bit counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            packet_q <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (bus.send) packet_q <= {{STOP_BITS{1'b1}}, bus.data_in, 1'b0};
                LOAD: begin
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                end
                SEND: begin
                    if (baud_tc) begin
                        baud_cnt <= '0;
                        if (!last_bit) bit_cnt <= bit_cnt + 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Next state and outputs; tx is the only path fed by an input (ser_bit)
    always_comb begin
        state_nxt  = state;
        bus.ld     = 1'b0;
        bus.shift  = 2'd0;
        bus.tx     = 1'b1;
        bus.busy   = 1'b0;
        bus.done   = 1'b0;
        bus.packet = packet_q;
        case (state)
            IDLE: if (bus.send) state_nxt = LOAD;
            LOAD: begin
                bus.ld    = 1'b1;
                bus.busy  = 1'b1;
                state_nxt = SEND;
            end
            SEND: begin
                bus.busy = 1'b1;
                bus.tx   = bus.ser_bit;
                if (baud_tc) begin
                    if (last_bit) state_nxt = DONE;
                    else          bus.shift = 2'd1;
                end
            end
            DONE: begin
                bus.busy  = 1'b1;
                bus.done  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: two instances (1 and 2 stop bits) each
// paired with a small behavioural shift register.
module tb_uart_tx_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    uart_tx_ctrl_if #(.DATA_BITS(8), .STOP_BITS(1)) b1 ();
    uart_tx_ctrl_if #(.DATA_BITS(8), .STOP_BITS(2)) b2 ();

    uart_tx_ctrl #(.CLKS_PER_BIT(4), .DATA_BITS(8), .STOP_BITS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(b1)
    );
    uart_tx_ctrl #(.CLKS_PER_BIT(4), .DATA_BITS(8), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(b2)
    );

    // Shift registers downstream of each sequencer (never reset)
    logic [9:0]  sr1;
    logic [10:0] sr2;
    always @(posedge clk) begin
        if (b1.ld) sr1 <= b1.packet;
        else if (b1.shift == 2'd1) sr1 <= {1'b1, sr1[9:1]};
        if (b2.ld) sr2 <= b2.packet;
        else if (b2.shift == 2'd1) sr2 <= {1'b1, sr2[10:1]};
    end
    assign b1.ser_bit = sr1[0];
    assign b2.ser_bit = sr2[0];

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rst_n = 1'b0;
        b1.send = 1'b1; b1.data_in = 8'hFF;
        b2.send = 1'b1; b2.data_in = 8'hFF;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_chk++; if (b1.tx !== 1'b1 || b2.tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx c%0d got %b/%b exp 1", c, b1.tx, b2.tx); end
            n_chk++; if (b1.busy !== 1'b0 || b2.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy c%0d got %b/%b exp 0", c, b1.busy, b2.busy); end
            n_chk++; if (b1.ld !== 1'b0 || b2.ld !== 1'b0) begin n_fail++; $display("FAIL reset_ld c%0d got %b/%b exp 0", c, b1.ld, b2.ld); end
            n_chk++; if (b1.shift !== 2'd0 || b2.shift !== 2'd0) begin n_fail++; $display("FAIL reset_shift c%0d got %0d/%0d exp 0", c, b1.shift, b2.shift); end
            n_chk++; if (b1.done !== 1'b0 || b2.done !== 1'b0) begin n_fail++; $display("FAIL reset_done c%0d got %b/%b exp 0", c, b1.done, b2.done); end
            n_chk++; if (b1.packet !== 10'd0 || b2.packet !== 11'd0) begin n_fail++; $display("FAIL reset_packet c%0d got %h/%h exp 0", c, b1.packet, b2.packet); end
            if (c == 1) begin
                rst_n = 1'b1;
                b1.send = 1'b0;
                b2.send = 1'b0;
            end
        end
    endtask

    // Single frame on dut1 starting at the current negedge (cycle 0).
    // inj >= 0 pulses send with data 0x3C at that cycle.
    task automatic frame1(input string nm, input logic [7:0] d, input logic [9:0] ep, input int inj);
        logic etx, esh;
        for (int cyc = 0; cyc <= 43; cyc++) begin
            if (cyc > 0) @(negedge clk);
            etx = (cyc >= 2 && cyc <= 41) ? ep[(cyc-2)/4] : 1'b1;
            esh = (cyc >= 5 && cyc <= 37 && ((cyc - 2) % 4) == 3);
            n_chk++; if (b1.tx !== etx) begin n_fail++; $display("FAIL %s tx cyc %0d got %b exp %b", nm, cyc, b1.tx, etx); end
            n_chk++; if (b1.ld !== (cyc == 1)) begin n_fail++; $display("FAIL %s ld cyc %0d got %b exp %b", nm, cyc, b1.ld, cyc == 1); end
            n_chk++; if (b1.shift !== {1'b0, esh}) begin n_fail++; $display("FAIL %s shift cyc %0d got %0d exp %0d", nm, cyc, b1.shift, esh); end
            n_chk++; if (b1.busy !== (cyc >= 1 && cyc <= 42)) begin n_fail++; $display("FAIL %s busy cyc %0d got %b", nm, cyc, b1.busy); end
            n_chk++; if (b1.done !== (cyc == 42)) begin n_fail++; $display("FAIL %s done cyc %0d got %b exp %b", nm, cyc, b1.done, cyc == 42); end
            if (cyc == 1 || cyc == 43) begin
                n_chk++; if (b1.packet !== ep) begin n_fail++; $display("FAIL %s packet cyc %0d got %b exp %b", nm, cyc, b1.packet, ep); end
            end
            b1.send = (cyc == 0) || (cyc == inj);
            if (cyc == 0) b1.data_in = d;
            if (cyc == inj) b1.data_in = 8'h3C;
        end
        b1.send = 1'b0;
    endtask

    task automatic test_single_frame();
        @(negedge clk);
        frame1("single", 8'hA5, 10'b1101001010, -1);
    endtask

    task automatic test_ignore_send();
        @(negedge clk);
        frame1("ignore", 8'hA5, 10'b1101001010, 10);
    endtask

    task automatic test_back_to_back();
        int nsh = 0;
        logic etx;
        @(negedge clk);
        for (int cyc = 0; cyc <= 86; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (cyc >= 2 && cyc <= 41)      etx = (cyc >= 38);
            else if (cyc >= 45 && cyc <= 84) etx = (cyc >= 49);
            else                             etx = 1'b1;
            if (b1.shift == 2'd1) nsh++;
            n_chk++; if (b1.tx !== etx) begin n_fail++; $display("FAIL b2b tx cyc %0d got %b exp %b", cyc, b1.tx, etx); end
            n_chk++; if (b1.ld !== (cyc == 1 || cyc == 44)) begin n_fail++; $display("FAIL b2b ld cyc %0d got %b", cyc, b1.ld); end
            n_chk++; if (b1.done !== (cyc == 42 || cyc == 85)) begin n_fail++; $display("FAIL b2b done cyc %0d got %b", cyc, b1.done); end
            n_chk++; if (b1.busy !== !(cyc == 0 || cyc == 43 || cyc == 86)) begin n_fail++; $display("FAIL b2b busy cyc %0d got %b", cyc, b1.busy); end
            if (cyc == 44) begin
                n_chk++; if (b1.packet !== 10'b1111111110) begin n_fail++; $display("FAIL b2b packet2 got %b exp 1111111110", b1.packet); end
            end
            if (cyc == 0)  begin b1.send = 1'b1; b1.data_in = 8'h00; end
            if (cyc == 42) b1.data_in = 8'hFF;
            if (cyc == 85) b1.send = 1'b0;
        end
        n_chk++; if (nsh != 18) begin n_fail++; $display("FAIL b2b shift_count got %0d exp 18", nsh); end
    endtask

    task automatic test_reset_mid_frame();
        @(negedge clk);
        b1.send = 1'b1; b1.data_in = 8'hA5;
        for (int cyc = 1; cyc <= 25; cyc++) begin
            @(negedge clk);
            if (cyc == 1) b1.send = 1'b0;
            if (cyc == 21) begin
                n_chk++; if (b1.packet !== 10'd0) begin n_fail++; $display("FAIL rst_mid packet got %b exp 0", b1.packet); end
                n_chk++; if (b1.ld !== 1'b0 || b1.done !== 1'b0) begin n_fail++; $display("FAIL rst_mid ld/done got %b/%b exp 0/0", b1.ld, b1.done); end
            end
            if (cyc >= 21 && cyc <= 24) begin
                n_chk++; if (b1.tx !== 1'b1) begin n_fail++; $display("FAIL rst_mid tx cyc %0d got %b exp 1", cyc, b1.tx); end
                n_chk++; if (b1.busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid busy cyc %0d got %b exp 0", cyc, b1.busy); end
                n_chk++; if (b1.shift !== 2'd0) begin n_fail++; $display("FAIL rst_mid shift cyc %0d got %0d exp 0", cyc, b1.shift); end
            end
            if (cyc == 20) rst_n = 1'b0;
            if (cyc == 21) rst_n = 1'b1;
        end
        frame1("rst_frame", 8'h55, 10'b1010101010, -1);
    endtask

    task automatic test_two_stop();
        logic etx, esh;
        logic [10:0] ep = 11'b11100000010;
        @(negedge clk);
        for (int cyc = 0; cyc <= 47; cyc++) begin
            if (cyc > 0) @(negedge clk);
            etx = (cyc >= 2 && cyc <= 45) ? ep[(cyc-2)/4] : 1'b1;
            esh = (cyc >= 5 && cyc <= 41 && ((cyc - 2) % 4) == 3);
            n_chk++; if (b2.tx !== etx) begin n_fail++; $display("FAIL stop2 tx cyc %0d got %b exp %b", cyc, b2.tx, etx); end
            n_chk++; if (b2.ld !== (cyc == 1)) begin n_fail++; $display("FAIL stop2 ld cyc %0d got %b", cyc, b2.ld); end
            n_chk++; if (b2.shift !== {1'b0, esh}) begin n_fail++; $display("FAIL stop2 shift cyc %0d got %0d exp %0d", cyc, b2.shift, esh); end
            n_chk++; if (b2.busy !== (cyc >= 1 && cyc <= 46)) begin n_fail++; $display("FAIL stop2 busy cyc %0d got %b", cyc, b2.busy); end
            n_chk++; if (b2.done !== (cyc == 46)) begin n_fail++; $display("FAIL stop2 done cyc %0d got %b", cyc, b2.done); end
            if (cyc == 1) begin
                n_chk++; if (b2.packet !== ep) begin n_fail++; $display("FAIL stop2 packet got %b exp %b", b2.packet, ep); end
            end
            b2.send = (cyc == 0);
            if (cyc == 0) b2.data_in = 8'h81;
        end
        b2.send = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        b1.send = 1'b0; b1.data_in = '0;
        b2.send = 1'b0; b2.data_in = '0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_ignore_send();
        test_reset_mid_frame();
        test_two_stop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
- Transmit-side sequencer that sits directly upstream of the UART transmit shift register.
- Accepts a byte via a send strobe and frames it as start bit, data LSB-first, then stop bit(s).
- Issues load/shift commands to the shift register at baud rate and gates its serial LSB onto the tx line, holding the line idle-high outside a frame.
- Reports busy and a one-cycle done pulse to the host logic.

Parameters:
- CLKS_PER_BIT, 868: clk cycles per serial bit (100 MHz / 115200); legal range >= 2.
- DATA_BITS, 8: payload width.
- STOP_BITS, 1: number of stop bits, 1 or 2.
- PKT (localparam), DATA_BITS+1+STOP_BITS: frame width; matches the shift register's packetSize.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- send  input  1  request to transmit data_in; sampled only in IDLE.
- data_in  input  DATA_BITS  byte to transmit.
- ld  output  1  shift-register load enable.
- shift  output  2  shift-register command: 0=hold, 1=right shift; 2 never driven.
- packet  output  PKT  framed word for shift-register dIn: {STOP_BITS ones, data, 1'b0}.
- ser_bit  input  1  shift-register dOut[0].
- tx  output  1  serial line.
- busy  output  1  frame in progress.
- done  output  1  one-cycle pulse at end of frame.

Behaviour:
- Reset is synchronous: rst_n low at a clk edge forces state=IDLE, counters=0 and packet=0.
- During and after reset, outputs are tx=1, busy=0, done=0, ld=0, shift=0.
- Outputs are decoded from registers only. The single combinational input-to-output path is ser_bit -> tx.
- FSM states: IDLE, LOAD, SEND, DONE.
- IDLE:
  - tx=1, busy=0.
  - If send=1, capture packet <= {STOP_BITS ones, data_in, 0} and go to LOAD.
- LOAD (1 cycle):
  - ld=1, busy=1, tx=1.
  - Shift register takes packet at the end of this cycle.
  - Clear baud counter and bit counter; go to SEND.
- SEND:
  - busy=1, tx=ser_bit.
  - Baud counter runs 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT).
  - At terminal count with bit counter < PKT-1: shift=1 for that single cycle, bit counter +1, baud counter wraps to 0.
  - At terminal count with bit counter == PKT-1: shift=0; go to DONE.
  - Each frame bit is on tx for exactly CLKS_PER_BIT cycles; exactly PKT-1 shift pulses per frame.
- DONE (1 cycle):
  - done=1, busy=1, tx=1; go to IDLE.
- Timing, with the accept cycle as cycle 0:
  - LOAD at cycle 1.
  - Start bit on tx from cycle 2.
  - done at cycle 2+PKT*CLKS_PER_BIT.
- send outside IDLE is ignored, and data_in changes outside IDLE have no effect. packet holds its value until the next accept.
- send held high continuously gives back-to-back frames with exactly one IDLE cycle between DONE and the next LOAD.
- Reset mid-frame:
  - Next cycle IDLE, tx=1.
  - Shift-register contents (unreset) are masked by the tx mux.
  - The next send starts a clean frame.

Test Plan:
1. rst_n low 2 cycles, send=1 throughout -> tx=1, busy=0, ld=0, shift=0, done=0, packet=0; no LOAD while in reset.
2. CLKS_PER_BIT=4, DATA_BITS=8, STOP_BITS=1, DUT plus shift register (packetSize=10); send=1 for one cycle with data_in=0xA5 ->
   - ld=1 at cycle 1 only; packet=10'b1_10100101_0.
   - tx=0,1,0,1,0,0,1,0,1,1, 4 cycles each, cycles 2..41.
   - 9 shift pulses; done=1 at cycle 42 only; busy high cycles 1..42.
3. send held high, data_in=0x00 then 0xFF at first done -> accepts at cycles 0 and 43; done at 42 and 85; second frame tx=0, eight 1s, 1.
4. During a frame, pulse send at cycle 10 with data_in=0x3C -> ignored; packet stays 0x A5 frame; no extra ld; done still at 42.
5. rst_n low at cycle 20 for 1 cycle -> cycle 21 tx=1, busy=0, shift=0. A new send=0x55 at cycle 25 gives a correct full frame with done at cycle 67.
6. STOP_BITS=2, CLKS_PER_BIT=4, data_in=0x81 -> packet=11'b11_10000001_0; tx ends with two 1-bits; 10 shift pulses; done at cycle 46.
